// File: rtl/eth_pkt_if_field_replace_if.sv
// Packet stream interface: one word per val/ready handshake, framed by sop/eop.
// mod gives the valid byte count of the eop word and is carried through untouched.
interface eth_pkt_if #(
   parameter int unsigned D_WIDTH     = 64,
   parameter int unsigned TUSER_WIDTH = 4
);
   localparam int unsigned MOD_WIDTH = (D_WIDTH > 8) ? $clog2(D_WIDTH / 8) : 1;

   logic [D_WIDTH-1:0]     data;
   logic [TUSER_WIDTH-1:0] tuser;
   logic                   sop;
   logic                   eop;
   logic [MOD_WIDTH-1:0]   mod;
   logic                   val;
   logic                   ready;

   modport i (input data, tuser, sop, eop, mod, val, output ready);
   modport o (output data, tuser, sop, eop, mod, val, input ready);
endinterface

// File: rtl/eth_pkt_if_field_replace.sv
// Registered multi-slot byte-lane replacer for the eth_pkt_if stream. Slot config is
// snapshotted on each SOP word so a packet is never rewritten with mixed settings.
module eth_pkt_if_field_replace #(
   parameter int unsigned SLOT_CNT    = 4,
   parameter int unsigned WCNT_WIDTH  = 8,
   parameter int unsigned D_WIDTH     = 64,
   parameter int unsigned TUSER_WIDTH = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [SLOT_CNT-1:0]            slot_en_i,
   input  logic [SLOT_CNT*WCNT_WIDTH-1:0] slot_word_i,
   input  logic [SLOT_CNT*D_WIDTH/8-1:0]  slot_mask_i,
   input  logic [SLOT_CNT*D_WIDTH-1:0]    slot_data_i,
   input  logic                           tuser_replace_en_i,
   input  logic [TUSER_WIDTH-1:0]         tuser_i,
   output logic [SLOT_CNT-1:0]            hit_o,
   output logic                           err_o,
   eth_pkt_if.i                           pkt_i,
   eth_pkt_if.o                           pkt_o
);
   localparam int unsigned BYTE_CNT  = D_WIDTH / 8;
   localparam int unsigned MOD_WIDTH = (D_WIDTH > 8) ? $clog2(D_WIDTH / 8) : 1;

   typedef enum logic [0:0] {StIdle, StInPkt} state_e;

   state_e st_q, st_d;

   logic [WCNT_WIDTH-1:0]          cnt_q, cnt_d, cnt_e;
   logic [SLOT_CNT-1:0]            en_q, en_e;
   logic [SLOT_CNT*WCNT_WIDTH-1:0] word_q, word_e;
   logic [SLOT_CNT*BYTE_CNT-1:0]   mask_q, mask_e;
   logic [SLOT_CNT*D_WIDTH-1:0]    sdata_q, sdata_e;

   logic                   rdy, acc, active, err_d;
   logic [SLOT_CNT-1:0]    match, hit_d, hit_q;
   logic [BYTE_CNT-1:0]    lane_taken;
   logic [D_WIDTH-1:0]     data_d, data_q;
   logic [TUSER_WIDTH-1:0] tuser_d, tuser_q;
   logic                   sop_q, eop_q, val_q, err_q;
   logic [MOD_WIDTH-1:0]   mod_q;

   assign rdy         = !val_q || pkt_o.ready;
   assign pkt_i.ready = rdy;
   assign acc         = pkt_i.val && rdy;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) st_q <= StIdle;
      else        st_q <= st_d;
   end

   // A stray SOP inside a packet restarts framing exactly like a fresh SOP.
   always_comb begin
      st_d = st_q;
      if (acc) begin
         if (pkt_i.sop)                          st_d = pkt_i.eop ? StIdle : StInPkt;
         else if (st_q == StInPkt && pkt_i.eop)  st_d = StIdle;
      end
   end

   always_comb begin
      en_e    = pkt_i.sop ? slot_en_i   : en_q;
      word_e  = pkt_i.sop ? slot_word_i : word_q;
      mask_e  = pkt_i.sop ? slot_mask_i : mask_q;
      sdata_e = pkt_i.sop ? slot_data_i : sdata_q;
      cnt_e   = pkt_i.sop ? '0 : cnt_q;
      active  = acc && (pkt_i.sop || st_q == StInPkt);
      err_d   = acc && (pkt_i.sop ? (st_q == StInPkt) : (st_q == StIdle));

      // cnt_q holds the offset of the next word; it saturates instead of wrapping.
      cnt_d = cnt_q;
      if (active) cnt_d = (cnt_e == '1) ? cnt_e : cnt_e + 1'b1;

      for (int s = 0; s < SLOT_CNT; s++) begin
         match[s] = active && en_e[s] && (word_e[s*WCNT_WIDTH +: WCNT_WIDTH] == cnt_e);
      end

      // Mask MSB pairs with lane 0 (first wire byte), mirroring the data layout.
      data_d     = pkt_i.data;
      hit_d      = '0;
      lane_taken = '0;
      for (int s = 0; s < SLOT_CNT; s++) begin
         for (int k = 0; k < BYTE_CNT; k++) begin
            if (match[s] && mask_e[s*BYTE_CNT + BYTE_CNT-1-k] && !lane_taken[k]) begin
               lane_taken[k]               = 1'b1;
               hit_d[s]                    = 1'b1;
               data_d[D_WIDTH-1-8*k -: 8] = sdata_e[s*D_WIDTH + D_WIDTH-1-8*k -: 8];
            end
         end
      end

      tuser_d = (pkt_i.sop && tuser_replace_en_i) ? tuser_i : pkt_i.tuser;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q   <= '0;
         en_q    <= '0;
         word_q  <= '0;
         mask_q  <= '0;
         sdata_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (acc && pkt_i.sop) begin
            en_q    <= slot_en_i;
            word_q  <= slot_word_i;
            mask_q  <= slot_mask_i;
            sdata_q <= slot_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         val_q   <= 1'b0;
         data_q  <= '0;
         tuser_q <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         mod_q   <= '0;
         hit_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         hit_q <= hit_d;
         err_q <= err_d;
         if (rdy) begin
            val_q <= pkt_i.val;
            if (pkt_i.val) begin
               data_q  <= data_d;
               tuser_q <= tuser_d;
               sop_q   <= pkt_i.sop;
               eop_q   <= pkt_i.eop;
               mod_q   <= pkt_i.mod;
            end
         end
      end
   end

   assign pkt_o.val   = val_q;
   assign pkt_o.data  = data_q;
   assign pkt_o.tuser = tuser_q;
   assign pkt_o.sop   = sop_q;
   assign pkt_o.eop   = eop_q;
   assign pkt_o.mod   = mod_q;
   assign hit_o       = hit_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_eth_pkt_if_field_replace.sv
// Bench for eth_pkt_if_field_replace: packet-level reference model plus directed
// packets with literal expectations for offsets, priority, snapshot, framing and reset.
module tb_eth_pkt_if_field_replace;
   localparam int unsigned SLOTS = 4;
   localparam int unsigned W     = 8;
   localparam int unsigned DW    = 64;
   localparam int unsigned TW    = 4;
   localparam int unsigned BC    = 8;
   localparam int          MAX_C = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [SLOTS-1:0]    slot_en;
   logic [SLOTS*W-1:0]  slot_word;
   logic [SLOTS*BC-1:0] slot_mask;
   logic [SLOTS*DW-1:0] slot_data;
   logic                tre;
   logic [TW-1:0]       tus;
   logic [SLOTS-1:0]    hit;
   logic                err;

   eth_pkt_if #(.D_WIDTH(DW), .TUSER_WIDTH(TW)) in_if ();
   eth_pkt_if #(.D_WIDTH(DW), .TUSER_WIDTH(TW)) out_if ();

   eth_pkt_if_field_replace #(
      .SLOT_CNT(SLOTS), .WCNT_WIDTH(W), .D_WIDTH(DW), .TUSER_WIDTH(TW)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_n),
      .slot_en_i          (slot_en),
      .slot_word_i        (slot_word),
      .slot_mask_i        (slot_mask),
      .slot_data_i        (slot_data),
      .tuser_replace_en_i (tre),
      .tuser_i            (tus),
      .hit_o              (hit),
      .err_o              (err),
      .pkt_i              (in_if),
      .pkt_o              (out_if)
   );

   logic rand_rdy = 1'b0;
   logic rdy_tb   = 1'b1;
   assign out_if.ready = rdy_tb;
   always @(posedge clk) begin
      #1 rdy_tb = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  tuser;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
   } word_t;

   word_t       exp_q[$];
   logic [63:0] obs_q[$];

   // Reference model: packet position and the config captured at its SOP.
   bit                  m_in;
   int                  m_idx;
   logic [SLOTS-1:0]    m_en;
   logic [SLOTS*W-1:0]  m_word;
   logic [SLOTS*BC-1:0] m_mask;
   logic [SLOTS*DW-1:0] m_data;

   task automatic model_step(output word_t e, output logic [SLOTS-1:0] h, output logic er);
      bit act;
      int c;
      e  = '{data: in_if.data, tuser: in_if.tuser, sop: in_if.sop, eop: in_if.eop,
             mod: in_if.mod};
      h  = '0;
      er = 1'b0;
      act = 1'b0;
      if (in_if.sop) begin
         er     = m_in;
         m_en   = slot_en;
         m_word = slot_word;
         m_mask = slot_mask;
         m_data = slot_data;
         m_idx  = 0;
         act    = 1'b1;
         m_in   = !in_if.eop;
         if (tre) e.tuser = tus;
      end else if (!m_in) begin
         er = 1'b1;
      end else begin
         m_idx++;
         act = 1'b1;
         if (in_if.eop) m_in = 1'b0;
      end
      c = (m_idx > MAX_C) ? MAX_C : m_idx;
      if (act) begin
         for (int k = 0; k < BC; k++) begin
            for (int s = 0; s < SLOTS; s++) begin
               if (m_en[s] && int'(m_word[s*W +: W]) == c && m_mask[s*BC + 7 - k]) begin
                  e.data[63-8*k -: 8] = m_data[s*DW + 63 - 8*k -: 8];
                  h[s] = 1'b1;
                  break;
               end
            end
         end
      end
   endtask

   logic [SLOTS-1:0] p_hit, last_hit;
   logic             p_err, p_valid, stall_prev;
   logic [63:0]      p_data;
   word_t            prev_w;
   int               hit0_cnt = 0;
   int               err_cnt  = 0;

   always @(negedge clk) begin
      word_t            e, cur;
      logic [SLOTS-1:0] h;
      logic             er;
      if (!rst_n) begin
         p_valid    = 1'b0;
         p_hit      = '0;
         p_err      = 1'b0;
         stall_prev = 1'b0;
         m_in       = 1'b0;
         exp_q.delete();
      end else begin
         chk("hit_pulse", hit, p_valid ? p_hit : '0);
         chk("err_pulse", err, p_valid ? p_err : 1'b0);
         if (hit[0]) hit0_cnt++;
         if (hit != '0) last_hit = hit;
         if (err) err_cnt++;
         cur = '{data: out_if.data, tuser: out_if.tuser, sop: out_if.sop, eop: out_if.eop,
                 mod: out_if.mod};
         if (p_valid) begin
            chk("latency_val", out_if.val, 1'b1);
            chk("latency_data", out_if.data, p_data);
         end
         if (stall_prev) chk("hold_stable", cur, prev_w);
         if (out_if.val && out_if.ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_word: got %h, expected no word", out_if.data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", cur.data, e.data);
               chk("out_ctrl", {cur.tuser, cur.sop, cur.eop, cur.mod},
                   {e.tuser, e.sop, e.eop, e.mod});
            end
            obs_q.push_back(out_if.data);
         end
         stall_prev = out_if.val && !out_if.ready;
         prev_w     = cur;
         if (in_if.val && in_if.ready) begin
            model_step(e, h, er);
            exp_q.push_back(e);
            p_valid = 1'b1;
            p_hit   = h;
            p_err   = er;
            p_data  = e.data;
         end else begin
            p_valid = 1'b0;
         end
      end
   end

   task automatic send(input logic [63:0] d, input logic s, input logic e,
                       input logic [2:0] m = 3'd0, input logic [3:0] tu = 4'd0);
      int guard = 0;
      in_if.data  = d;
      in_if.sop   = s;
      in_if.eop   = e;
      in_if.mod   = m;
      in_if.tuser = tu;
      in_if.val   = 1'b1;
      @(negedge clk);
      while (!in_if.ready) begin
         guard++;
         if (guard > 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got ready=0, expected ready=1");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 in_if.val = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int s, input logic en, input int w, input logic [7:0] m,
                           input logic [63:0] d);
      slot_en[s]            = en;
      slot_word[s*W +: W]   = 8'(w);
      slot_mask[s*BC +: BC] = m;
      slot_data[s*DW +: DW] = d;
   endtask

   task automatic clr_slots();
      slot_en   = '0;
      slot_word = '0;
      slot_mask = '0;
      slot_data = '0;
      tre       = 1'b0;
      tus       = '0;
   endtask

   int base, h0, e0, total;

   initial begin
      in_if.val   = 1'b0;
      in_if.data  = '0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
      in_if.mod   = '0;
      in_if.tuser = '0;
      clr_slots();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_val", out_if.val, 1'b0);
      chk("rst_data", out_if.data, 64'h0);
      chk("rst_pulses", {hit, err}, 5'h0);
      chk("rst_ready", in_if.ready, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Header bytes of word 0 rewritten; tuser replaced on SOP only.
      set_slot(0, 1'b1, 0, 8'hFC, 64'h0011_2233_4455_0000);
      tre = 1'b1;
      tus = 4'hA;
      base = obs_q.size();
      h0   = hit0_cnt;
      send(64'hF0F1_F2F3_F4F5_F6F7, 1'b1, 1'b0, 3'd0, 4'h3);
      send(64'h1, 1'b0, 1'b0, 3'd0, 4'h3);
      send(64'h2, 1'b0, 1'b1, 3'd5, 4'h3);
      drain();
      chk("t1_w0", obs_q[base], 64'h0011_2233_4455_F6F7);
      chk("t1_w1", obs_q[base+1], 64'h1);
      chk("t1_w2", obs_q[base+2], 64'h2);
      chk("t1_hit0_pulses", hit0_cnt - h0, 1);

      // Two slots on one word: lowest index wins per lane, both report a hit.
      clr_slots();
      set_slot(0, 1'b1, 1, 8'hF0, {8{8'hAA}});
      set_slot(1, 1'b1, 1, 8'hFF, {8{8'hBB}});
      base = obs_q.size();
      send(64'd10, 1'b1, 1'b0);
      send(64'd11, 1'b0, 1'b0);
      send(64'd12, 1'b0, 1'b1);
      drain();
      chk("t2_w0", obs_q[base], 64'd10);
      chk("t2_w1", obs_q[base+1], 64'hAAAA_AAAA_BBBB_BBBB);
      chk("t2_hit", last_hit, 4'b0011);

      // Offset change mid-packet only applies from the next SOP.
      clr_slots();
      set_slot(0, 1'b1, 1, 8'hFF, {8{8'hCC}});
      base = obs_q.size();
      send(64'd20, 1'b1, 1'b0);
      set_slot(0, 1'b1, 2, 8'hFF, {8{8'hCC}});
      send(64'd21, 1'b0, 1'b0);
      send(64'd22, 1'b0, 1'b1);
      send(64'd30, 1'b1, 1'b0);
      send(64'd31, 1'b0, 1'b0);
      send(64'd32, 1'b0, 1'b1);
      drain();
      chk("t3_p1w1", obs_q[base+1], {8{8'hCC}});
      chk("t3_p1w2", obs_q[base+2], 64'd22);
      chk("t3_p2w1", obs_q[base+4], 64'd31);
      chk("t3_p2w2", obs_q[base+5], {8{8'hCC}});

      // Framing errors: orphan word, then SOP without preceding EOP.
      clr_slots();
      set_slot(0, 1'b1, 0, 8'hFF, {8{8'hEE}});
      set_slot(1, 1'b1, 1, 8'hFF, {8{8'h77}});
      base = obs_q.size();
      e0   = err_cnt;
      send(64'd40, 1'b0, 1'b1);
      send(64'd50, 1'b1, 1'b0);
      send(64'd51, 1'b0, 1'b0);
      send(64'd60, 1'b1, 1'b0);
      send(64'd61, 1'b0, 1'b1);
      drain();
      chk("t5_err_pulses", err_cnt - e0, 2);
      chk("t5_orphan", obs_q[base], 64'd40);
      chk("t5_p2w0", obs_q[base+3], {8{8'hEE}});
      chk("t5_p2w1", obs_q[base+4], {8{8'h77}});

      // Counter saturation: offset MAX_C matches every word from there on.
      clr_slots();
      set_slot(0, 1'b1, MAX_C, 8'hFF, {8{8'hDD}});
      base = obs_q.size();
      for (int i = 0; i < 260; i++) send(64'(1000 + i), i == 0, i == 259);
      drain();
      chk("t6_w0", obs_q[base], 64'd1000);
      chk("t6_w254", obs_q[base+254], 64'd1254);
      chk("t6_w255", obs_q[base+255], {8{8'hDD}});
      chk("t6_w259", obs_q[base+259], {8{8'hDD}});

      // Random backpressure and configs, including mid-packet config churn.
      rand_rdy = 1'b1;
      base  = obs_q.size();
      total = 0;
      for (int p = 0; p < 100; p++) begin
         int len;
         len = $urandom_range(1, 5);
         for (int s = 0; s < SLOTS; s++) begin
            set_slot(s, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 8'($urandom),
                     {$urandom, $urandom});
         end
         tre = 1'($urandom_range(0, 1));
         tus = 4'($urandom);
         for (int i = 0; i < len; i++) begin
            if (i == 1 && p % 3 == 0) set_slot(0, 1'b1, 1, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
            send({$urandom, $urandom}, i == 0, i == len - 1, 3'($urandom), 4'($urandom));
            total++;
         end
      end
      drain();
      chk("t4_word_count", obs_q.size() - base, total);
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;

      // Asynchronous reset mid-packet, then a clean packet.
      clr_slots();
      set_slot(0, 1'b1, 0, 8'hFF, {8{8'h99}});
      send(64'd70, 1'b1, 1'b0);
      send(64'd71, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_val", out_if.val, 1'b0);
      chk("t7_rst_pulses", {hit, err}, 5'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = obs_q.size();
      send(64'd80, 1'b1, 1'b0);
      send(64'd81, 1'b0, 1'b1);
      drain();
      chk("t7_w0", obs_q[base], {8{8'h99}});
      chk("t7_w1", obs_q[base+1], 64'd81);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
